mat_stream_tx: RTL and testbench



---
 rtl/mat_stream_tx.sv | 143 ++++++++++++++
 tb/tb_mat_stream_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_tx.sv
// mat_stream_tx: streams a ROWS x COLS matrix from sync-read memory to a byte UART transmitter.
// Optional macro ROW_DELIM_EN appends byte 8'h0A after the last element of every row.
module mat_stream_tx #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] elem_idx
);
    localparam int NB = DATA_W / 8;
    localparam int N  = ROWS * COLS;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;

    if (N + BASE_ADDR > 2 ** ADDR_W) begin : g_addr_chk
        $error("mat_stream_tx: matrix does not fit in the address space");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 32) begin : g_width_chk
        $error("mat_stream_tx: DATA_W must be a multiple of 8 in 8..32");
    end

    typedef enum logic [3:0] {
        IDLE, READ, LATCH, SEND, WAIT_ACK, WAIT_DONE, FIN
`ifdef ROW_DELIM_EN
        , SEND_DELIM, DELIM_ACK, DELIM_DONE
`endif
    } state_t;

    state_t            state, next;
    logic              start_q, start_edge, last_byte, last_elem, byte_inc, elem_inc;
    logic [BW-1:0]     byte_idx, k;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        byte_q, sel;

    assign start_edge = start & ~start_q;
    assign last_byte  = byte_idx == BW'(NB - 1);
    assign last_elem  = elem_idx == ADDR_W'(N - 1);
    // byte k counted from the far end of the element when sending MSB first
    assign k          = MSB_FIRST != 0 ? BW'(NB - 1) - byte_idx : byte_idx;
    assign sel        = data_q[8*k +: 8];

`ifdef ROW_DELIM_EN
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    logic [CW-1:0] col;
    logic          last_col;
    assign last_col = col == CW'(COLS - 1);
    assign tx_start = state == SEND || state == SEND_DELIM;
    assign tx_byte  = state == SEND ? sel : state == SEND_DELIM ? 8'h0A : byte_q;
`else
    assign tx_start = state == SEND;
    assign tx_byte  = state == SEND ? sel : byte_q;
`endif
    assign mem_rd_en = state == READ;
    assign mem_addr  = state == READ ? ADDR_W'(BASE_ADDR) + elem_idx : '0;
    assign busy      = state != IDLE;
    assign done      = state == FIN;

    always_comb begin
        next     = state;
        byte_inc = 1'b0;
        elem_inc = 1'b0;
        case (state)
            IDLE:      next = start_edge ? READ : IDLE;
            READ:      next = LATCH;
            LATCH:     next = SEND;
            SEND:      next = WAIT_ACK;
            WAIT_ACK:  next = tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: if (!tx_busy) begin
                if (!last_byte) begin
                    next     = SEND;
                    byte_inc = 1'b1;
                end
`ifdef ROW_DELIM_EN
                else if (last_col) next = SEND_DELIM;
`endif
                else if (!last_elem) begin
                    next     = READ;
                    elem_inc = 1'b1;
                end
                else next = FIN;
            end
            FIN:       next = IDLE;
`ifdef ROW_DELIM_EN
            SEND_DELIM: next = DELIM_ACK;
            DELIM_ACK:  next = tx_busy ? DELIM_DONE : DELIM_ACK;
            DELIM_DONE: if (!tx_busy) begin
                next     = last_elem ? FIN : READ;
                elem_inc = !last_elem;
            end
`endif
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            elem_idx <= '0;
            byte_idx <= '0;
            data_q   <= '0;
            byte_q   <= '0;
`ifdef ROW_DELIM_EN
            col      <= '0;
`endif
        end else begin
            state   <= next;
            start_q <= start;
            if (state == IDLE && start_edge) begin
                elem_idx <= '0;
                byte_idx <= '0;
`ifdef ROW_DELIM_EN
                col      <= '0;
`endif
            end
            if (state == LATCH) begin
                data_q   <= mem_rdata;
                byte_idx <= '0;
            end
            if (byte_inc) byte_idx <= byte_idx + 1'b1;
            if (elem_inc) begin
                elem_idx <= elem_idx + 1'b1;
`ifdef ROW_DELIM_EN
                col      <= last_col ? '0 : col + 1'b1;
`endif
            end
            if (tx_start) byte_q <= tx_byte;
        end
    end
endmodule

// File: tb/tb_mat_stream_tx.sv
// tb_mat_stream_tx: four parameter variants of mat_stream_tx checked against a byte/address scoreboard.
// Expected streams include 8'h0A row delimiters when ROW_DELIM_EN is defined.
module tb_mat_stream_tx;
`ifdef ROW_DELIM_EN
    localparam int DL = 1;
`else
    localparam int DL = 0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0, tx_busy_v = '0, rd_en_v, tx_start_v, busy_v, done_v;
    logic [5:0] addr_a [4];
    logic [5:0] eidx_a [4];
    logic [7:0] tx_byte_a [4];
    logic [7:0] exp_b [4][$];
    logic [5:0] exp_a [4][$];
    int n_tx [4], n_rd [4], n_done [4], ack_dly [4], acnt [4], bcnt [4];
    bit pend [4];
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int d, int a);
        case (d)
            0:       return a == 0 ? 32'h11 : a == 1 ? 32'h22 : a == 2 ? 32'h33 : a == 3 ? 32'h44 : 32'hEE;
            1, 2:    return a == 0 ? 32'hA1B2 : a == 1 ? 32'hC3D4 : 32'hEEEE;
            default: return a == 8 ? 32'h5A : a == 9 ? 32'h6B : a == 10 ? 32'h7C : 32'hFF;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int R  = g == 0 ? 2 : g == 3 ? 3 : 1;
        localparam int C  = g == 3 ? 1 : 2;
        localparam int DW = (g == 1 || g == 2) ? 16 : 8;
        logic [DW-1:0] mem [64];
        logic [DW-1:0] rdata;
        initial for (int a = 0; a < 64; a++) mem[a] = DW'(init_val(g, a));
        always @(posedge clk) if (rd_en_v[g]) rdata <= mem[addr_a[g]];
        mat_stream_tx #(.ROWS(R), .COLS(C), .DATA_W(DW), .ADDR_W(6),
                        .BASE_ADDR(g == 3 ? 8 : 0), .MSB_FIRST(g == 2 ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]),
            .mem_rd_en(rd_en_v[g]), .mem_addr(addr_a[g]), .mem_rdata(rdata),
            .tx_start(tx_start_v[g]), .tx_byte(tx_byte_a[g]), .tx_busy(tx_busy_v[g]),
            .busy(busy_v[g]), .done(done_v[g]), .elem_idx(eidx_a[g]));
    end

    // One clock step: scoreboard pops on reads/bytes, then the transmitter model advances.
    task automatic tick();
        logic [7:0] eb;
        logic [5:0] ea;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            if (rd_en_v[d]) begin
                n_rd[d]++;
                checks++;
                if (exp_a[d].size() == 0) begin
                    errs++; $display("FAIL rd_extra dut%0d got addr=%0d want no read", d, addr_a[d]);
                end else begin
                    ea = exp_a[d].pop_front();
                    if (addr_a[d] !== ea) begin errs++; $display("FAIL rd_addr dut%0d got=%0d want=%0d", d, addr_a[d], ea); end
                end
            end
            if (tx_start_v[d]) begin
                n_tx[d]++;
                checks++;
                if (pend[d] || tx_busy_v[d]) begin errs++; $display("FAIL tx_overlap dut%0d got start while busy want idle", d); end
                checks++;
                if (exp_b[d].size() == 0) begin
                    errs++; $display("FAIL tx_extra dut%0d got=%h want no byte", d, tx_byte_a[d]);
                end else begin
                    eb = exp_b[d].pop_front();
                    if (tx_byte_a[d] !== eb) begin errs++; $display("FAIL tx_byte dut%0d got=%h want=%h", d, tx_byte_a[d], eb); end
                end
                pend[d] = 1'b1;
                acnt[d] = ack_dly[d];
            end
            if (done_v[d]) n_done[d]++;
            if (rst) begin
                pend[d] = 1'b0; bcnt[d] = 0; tx_busy_v[d] = 1'b0;
            end else if (pend[d]) begin
                if (acnt[d] == 0) begin pend[d] = 1'b0; tx_busy_v[d] = 1'b1; bcnt[d] = 10; end
                else acnt[d]--;
            end else if (bcnt[d] > 0) begin
                bcnt[d]--;
                if (bcnt[d] == 0) tx_busy_v[d] = 1'b0;
            end
        end
    endtask

    task automatic go(int d, output bit ok);
        int c = 0;
        start_v[d] = 1'b1;
        do begin tick(); c++; end while (!done_v[d] && c < 3000);
        ok = done_v[d];
        start_v[d] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic push_u0();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int e = 0; e < 4; e++) begin
            exp_a[0].push_back(6'(e));
            exp_b[0].push_back(v[e]);
            if (DL == 1 && e % 2 == 1) exp_b[0].push_back(8'h0A);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({busy_v[d], done_v[d], rd_en_v[d], tx_start_v[d]} !== 4'b0) begin
                errs++; $display("FAIL reset_ctl dut%0d got=%b want=0000", d, {busy_v[d], done_v[d], rd_en_v[d], tx_start_v[d]});
            end
            checks++;
            if (tx_byte_a[d] !== 8'h0 || addr_a[d] !== 6'h0 || eidx_a[d] !== 6'h0) begin
                errs++; $display("FAIL reset_data dut%0d got byte=%h addr=%0d idx=%0d want 0", d, tx_byte_a[d], addr_a[d], eidx_a[d]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int c = 0;
        int t0 = n_tx[0], r0 = n_rd[0], d0 = n_done[0];
        push_u0();
        start_v[0] = 1'b1;
        do begin tick(); c++; end while (!tx_start_v[0] && c < 20);
        checks++;
        if (c != 3) begin errs++; $display("FAIL first_tx_latency got=%0d want=3", c); end
        c = 0;
        while (!done_v[0] && c < 2000) begin tick(); c++; end
        checks++;
        if (!done_v[0]) begin errs++; $display("FAIL basic_done got timeout want done"); end
        repeat (30) tick();
        checks++;
        if (n_tx[0] - t0 != 4 + 2 * DL) begin errs++; $display("FAIL basic_bytes got=%0d want=%0d", n_tx[0] - t0, 4 + 2 * DL); end
        checks++;
        if (n_rd[0] - r0 != 4) begin errs++; $display("FAIL basic_reads got=%0d want=4", n_rd[0] - r0); end
        checks++;
        if (n_done[0] - d0 != 1) begin errs++; $display("FAIL basic_done_pulses got=%0d want=1", n_done[0] - d0); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errs++; $display("FAIL basic_busy_after got=%b want=0", busy_v[0]); end
        start_v[0] = 1'b0;
        tick();
    endtask

    task automatic test_no_restart();
        int c = 0;
        bit ok;
        int t0 = n_tx[0], r0 = n_rd[0], d0 = n_done[0];
        push_u0();
        start_v[0] = 1'b1;
        repeat (20) tick();
        start_v[0] = 1'b0;
        tick();
        start_v[0] = 1'b1;
        while (!done_v[0] && c < 2000) begin tick(); c++; end
        repeat (40) tick();
        checks++;
        if (n_tx[0] - t0 != 4 + 2 * DL) begin errs++; $display("FAIL norestart_bytes got=%0d want=%0d", n_tx[0] - t0, 4 + 2 * DL); end
        checks++;
        if (n_rd[0] - r0 != 4) begin errs++; $display("FAIL norestart_reads got=%0d want=4", n_rd[0] - r0); end
        checks++;
        if (n_done[0] - d0 != 1) begin errs++; $display("FAIL norestart_done got=%0d want=1", n_done[0] - d0); end
        start_v[0] = 1'b0;
        tick();
        push_u0();
        go(0, ok);
        checks++;
        if (!ok || exp_b[0].size() != 0 || exp_a[0].size() != 0) begin
            errs++; $display("FAIL restart got ok=%0d left=%0d want ok=1 left=0", ok, exp_b[0].size());
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        bit ok;
        int t0 = n_tx[0], d0 = n_done[0];
        push_u0();
        start_v[0] = 1'b1;
        while (n_tx[0] - t0 < 2 && c < 500) begin tick(); c++; end
        repeat (4) tick();
        start_v[0] = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({busy_v[0], done_v[0], rd_en_v[0], tx_start_v[0]} !== 4'b0 || tx_byte_a[0] !== 8'h0 || addr_a[0] !== 6'h0 || eidx_a[0] !== 6'h0) begin
            errs++; $display("FAIL abort_outputs got busy=%b byte=%h idx=%0d want 0", busy_v[0], tx_byte_a[0], eidx_a[0]);
        end
        rst = 1'b0;
        exp_b[0].delete();
        exp_a[0].delete();
        repeat (20) tick();
        checks++;
        if (n_done[0] != d0 || n_tx[0] - t0 != 2) begin
            errs++; $display("FAIL abort_quiet got done=%0d bytes=%0d want done=0 bytes=2", n_done[0] - d0, n_tx[0] - t0);
        end
        push_u0();
        go(0, ok);
        checks++;
        if (!ok || exp_b[0].size() != 0 || exp_a[0].size() != 0) begin
            errs++; $display("FAIL abort_restart got ok=%0d left=%0d want ok=1 left=0", ok, exp_b[0].size());
        end
    endtask

    task automatic test_width();
        bit ok;
        for (int d = 1; d <= 2; d++) begin
            int t0 = n_tx[d];
            exp_a[d].push_back(6'd0);
            exp_a[d].push_back(6'd1);
            if (d == 1) begin
                exp_b[d].push_back(8'hB2); exp_b[d].push_back(8'hA1);
                exp_b[d].push_back(8'hD4); exp_b[d].push_back(8'hC3);
            end else begin
                exp_b[d].push_back(8'hA1); exp_b[d].push_back(8'hB2);
                exp_b[d].push_back(8'hC3); exp_b[d].push_back(8'hD4);
            end
            if (DL == 1) exp_b[d].push_back(8'h0A);
            go(d, ok);
            checks++;
            if (!ok || exp_b[d].size() != 0 || exp_a[d].size() != 0) begin
                errs++; $display("FAIL width_done dut%0d got ok=%0d left=%0d want ok=1 left=0", d, ok, exp_b[d].size());
            end
            checks++;
            if (n_tx[d] - t0 != 4 + DL) begin errs++; $display("FAIL width_bytes dut%0d got=%0d want=%0d", d, n_tx[d] - t0, 4 + DL); end
        end
    endtask

    task automatic test_ack_delay();
        bit ok;
        int dl [2] = '{0, 5};
        logic [7:0] v [3] = '{8'h5A, 8'h6B, 8'h7C};
        for (int i = 0; i < 2; i++) begin
            int t0 = n_tx[3], r0 = n_rd[3];
            ack_dly[3] = dl[i];
            for (int e = 0; e < 3; e++) begin
                exp_a[3].push_back(6'(8 + e));
                exp_b[3].push_back(v[e]);
                if (DL == 1) exp_b[3].push_back(8'h0A);
            end
            go(3, ok);
            checks++;
            if (!ok || exp_b[3].size() != 0 || exp_a[3].size() != 0) begin
                errs++; $display("FAIL ack_done dly=%0d got ok=%0d left=%0d want ok=1 left=0", dl[i], ok, exp_b[3].size());
            end
            checks++;
            if (n_tx[3] - t0 != 3 + 3 * DL || n_rd[3] - r0 != 3) begin
                errs++; $display("FAIL ack_counts dly=%0d got bytes=%0d reads=%0d want %0d,3", dl[i], n_tx[3] - t0, n_rd[3] - r0, 3 + 3 * DL);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_restart();
        test_reset_mid();
        test_width();
        test_ack_delay();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
